dc_fifo_wr_packer: RTL and testbench
====================================

# dc_fifo_wr_packer

Write-side producer for the dual-clock FIFO. It accepts a byte stream with a valid/ready handshake and packs bytes little-endian into DW-bit words. It drives the FIFO write port (we/din), never writes while the FIFO reports full, and groups writes into bursts of up to BURST words that may only start when the FIFO is not nearly full. It sits entirely in the wr_clk domain, directly in front of the FIFO write port.

## Interface
- DW, 32: FIFO word width. Must be a multiple of 8 and at least 16. NB = DW/8 bytes per word.
- BURST, 4: maximum words per write burst, 1..255.
- wr_clk  in  1  write-domain clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous, active-low; clock wr_clk.
- clr  in  1  synchronous clear, same effect as rst; rst has priority.
- s_valid  in  1  source byte valid.
- s_data  in  8  source byte.
- s_last  in  1  marks the last byte of a packet; qualified by s_valid.
- s_ready  out  1  byte accepted when s_valid & s_ready.
- fifo_din  out  DW  word to the FIFO din; registered.
- fifo_we  out  1  FIFO write enable; combinational from registered state and fifo_full/fifo_full_n.
- fifo_full  in  1  FIFO full flag, registered in the FIFO with write lookahead.
- fifo_full_n  in  1  FIFO nearly-full flag; 1 means fewer than n free entries.
- wr_cnt  out  16  count of words written, wraps modulo 2^16.
- busy  out  1  1 while state == BURST.

## Operation
- Internal state:
  - pk[DW-1:0]: packing register.
  - bi: byte index, 0..NB-1.
  - pend: a completed word in fifo_din is waiting to be written.
  - plast: the pending word closes a packet.
  - bcnt: writes so far in the current burst.
  - FSM: IDLE or BURST.
- Accept: acc = s_valid & s_ready.
  - On acc, s_data is placed in byte lane bi, bits [8*bi+7:8*bi].
  - If bi == NB-1 or s_last:
    - fifo_din <= pk merged with the new byte; lanes above bi are zero-padded.
    - pend <= 1; plast <= s_last; bi <= 0; pk <= 0.
  - Otherwise bi <= bi+1.
- Write gate:
  - fifo_we = pend & !fifo_full & (state == BURST | !fifo_full_n).
  - Forced to 0 while rst == 0.
- s_ready = (!pend | fifo_we) & rst. A write in the same cycle frees the slot, so there is no bubble.
- pend clears on fifo_we unless a new word completes in the same cycle; in that case pend stays 1 and fifo_din is reloaded.
- wr_cnt increments on every fifo_we.
- FSM:
  - IDLE -> BURST on fifo_we, when BURST > 1 and the written word has plast == 0. bcnt <= 1.
  - BURST, on fifo_we: bcnt <= bcnt+1. Go to IDLE if bcnt+1 == BURST or plast == 1.
  - BURST ignores fifo_full_n; only fifo_full stalls it.
  - With BURST == 1, the FSM never leaves IDLE.
- clr or rst: pk, bi, pend, plast, bcnt, fifo_din, wr_cnt all go to 0; FSM goes to IDLE. A partially packed word is discarded. A pending word is dropped and not written.

## Timing
- Reset values: fifo_din = 0, fifo_we = 0, s_ready = 0 (while rst == 0, then 1), wr_cnt = 0, busy = 0.
- Latency: a word is complete at the acc edge of byte NB-1 (or of the s_last byte). fifo_we can assert in the next cycle. FIFO din/we are sampled at the edge after that.
- Sustained throughput: 1 byte per cycle, 1 word per NB cycles, as long as fifo_full == 0 and the burst gate is open.
- fifo_din is stable whenever pend == 1 and fifo_we == 0. The source may hold data indefinitely while s_ready == 0.
- fifo_full rises in the cycle after the filling write, because of the FIFO lookahead. The packer relies on that lookahead and needs no extra margin.
- Simultaneous clr and acc: clr wins and the byte is lost. Sources must not assert s_valid with clr.
- s_last with bi == NB-1 produces no padding; that word has plast = 1.

## Test plan
- Reset: hold rst = 0 for 3 cycles with s_valid = 1 -> fifo_we = 0, s_ready = 0, fifo_din = 0, wr_cnt = 0, busy = 0. Release -> s_ready = 1.
- Streaming, DW = 32, fifo_full = 0, fifo_full_n = 0, bytes 0x01..0x08 back to back -> writes 0x04030201 then 0x08070605, 4 cycles apart; s_ready never drops; wr_cnt = 2.
- Short packet 0xAA, 0xBB, 0xCC with s_last on 0xCC -> one write 0x00CCBBAA; FSM stays in IDLE; next byte starts in lane 0.
- Burst gate: fifo_full_n = 1 with pend in IDLE -> fifo_we = 0 and s_ready = 0. Drop fifo_full_n for one cycle -> write, busy = 1. Three more words are written with fifo_full_n = 1. The 5th word waits for fifo_full_n = 0.
- Full stall in BURST: force fifo_full = 1 for 5 cycles -> fifo_we = 0, fifo_din unchanged, s_ready = 0. Release -> write in the same cycle; bcnt continues.
- clr mid-word: accept 0x11, 0x22, pulse clr, then send 0x33..0x36 -> single write 0x36353433; wr_cnt = 1 counted from clr.

Source files
------------

// File: rtl/dc_fifo_wr_packer.sv
// Byte-stream to DW-bit word packer driving the write port of the dual-clock FIFO.
// Bytes pack little-endian; writes are grouped into bursts gated by the nearly-full flag.
//
// state   | meaning
// S_IDLE  | no burst open; a write needs fifo_full_n == 0
// S_BURST | burst open; writes continue regardless of fifo_full_n
module dc_fifo_wr_packer #(
  parameter int DW    = 32,
  parameter int BURST = 4
) (
  input  logic          wr_clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  input  logic          s_last,
  output logic          s_ready,
  output logic [DW-1:0] fifo_din,
  output logic          fifo_we,
  input  logic          fifo_full,
  input  logic          fifo_full_n,
  output logic [15:0]   wr_cnt,
  output logic          busy
);

  localparam int NB  = DW / 8;
  localparam int BIW = $clog2(NB);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   pk;
  logic [DW-1:0]   merged;
  logic [BIW-1:0]  bi;
  logic            pend;
  logic            plast;
  logic [7:0]      bcnt;
  logic            bcnt_hit;
  logic            acc;
  logic            done;

  // pk only ever holds lanes below bi, so lanes above bi come out zero-padded
  always_comb begin
    merged = pk;
    for (int l = 0; l < NB; l++) begin
      if (bi == BIW'(l)) merged[8*l +: 8] = s_data;
    end
  end

  assign acc      = s_valid & s_ready;
  assign done     = acc & (s_last | (bi == BIW'(NB - 1)));
  assign bcnt_hit = (({1'b0, bcnt} + 9'd1) == 9'(BURST));

  always_ff @(posedge wr_clk) begin
    if (!rst || clr) state <= S_IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (fifo_we && (BURST > 1) && !plast) state_nx = S_BURST;
      S_BURST: if (fifo_we && (bcnt_hit || plast))   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Writing in the same cycle frees the pending slot, so s_ready follows fifo_we
  always_comb begin
    fifo_we = rst & pend & ~fifo_full & ((state == S_BURST) | ~fifo_full_n);
    s_ready = rst & (~pend | fifo_we);
    busy    = (state == S_BURST);
  end

  always_ff @(posedge wr_clk) begin
    if (!rst || clr) begin
      pk       <= '0;
      bi       <= '0;
      pend     <= 1'b0;
      plast    <= 1'b0;
      bcnt     <= 8'd0;
      fifo_din <= '0;
      wr_cnt   <= 16'd0;
    end else begin
      if (acc) begin
        if (done) begin
          fifo_din <= merged;
          plast    <= s_last;
          bi       <= '0;
          pk       <= '0;
        end else begin
          pk <= merged;
          bi <= bi + BIW'(1);
        end
      end

      if (done)         pend <= 1'b1;
      else if (fifo_we) pend <= 1'b0;

      if (fifo_we) wr_cnt <= wr_cnt + 16'd1;

      if (state == S_IDLE && state_nx == S_BURST) begin
        bcnt <= 8'd1;
      end else if (state == S_BURST && fifo_we) begin
        bcnt <= (state_nx == S_IDLE) ? 8'd0 : bcnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dc_fifo_wr_packer.sv
// Bench for dc_fifo_wr_packer: fixed vector table, directed corner sequences,
// then random traffic against a byte/word queue model of the packer.
module tb_dc_fifo_wr_packer;

  localparam int DW    = 32;
  localparam int BURST = 4;
  localparam int NB    = DW / 8;

  logic          wr_clk;
  logic          rst;
  logic          clr;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_last;
  logic          s_ready;
  logic [DW-1:0] fifo_din;
  logic          fifo_we;
  logic          fifo_full;
  logic          fifo_full_n;
  logic [15:0]   wr_cnt;
  logic          busy;

  int total = 0;
  int bad   = 0;

  dc_fifo_wr_packer #(.DW(DW), .BURST(BURST)) dut (
    .wr_clk      (wr_clk),
    .rst         (rst),
    .clr         (clr),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .fifo_din    (fifo_din),
    .fifo_we     (fifo_we),
    .fifo_full   (fifo_full),
    .fifo_full_n (fifo_full_n),
    .wr_cnt      (wr_cnt),
    .busy        (busy)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        f;
    logic        fn;
    logic        we;
    logic        rdy;
    logic [31:0] din;
    logic [15:0] cnt;
    logic        busy;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    logic        last;
  } mw_t;

  vec_t        tbl[$];
  mw_t         exp_q[$];
  logic [7:0]  acc_q[$];
  bit          in_burst;
  int          bn;
  logic [15:0] m_cnt;
  logic [31:0] last_wr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                              input logic we, input logic rdy, input logic [31:0] din,
                              input logic [15:0] cnt, input logic bsy);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.f = 1'b0; t.fn = 1'b0;
    t.we = we; t.rdy = rdy; t.din = din; t.cnt = cnt; t.busy = bsy;
    return t;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    acc_q.delete();
    in_burst = 1'b0;
    bn       = 0;
    m_cnt    = 16'd0;
  endtask

  // One clock of stimulus; the model predicts the cycle from what it knows of pending words and the burst
  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic f, input logic fn, input logic c, output logic took);
    logic        pend_m, e_we, e_rdy;
    logic [31:0] w;
    mw_t         wd;
    s_valid = v; s_data = d; s_last = l; fifo_full = f; fifo_full_n = fn; clr = c;
    #1;
    pend_m = (exp_q.size() > 0);
    e_we   = pend_m && !f && (in_burst || !fn);
    e_rdy  = !pend_m || e_we;
    took   = v && e_rdy;
    chk("we", {63'd0, fifo_we}, {63'd0, e_we});
    chk("ready", {63'd0, s_ready}, {63'd0, e_rdy});
    chk("busy", {63'd0, busy}, {63'd0, in_burst});
    chk("wr_cnt", {48'd0, wr_cnt}, {48'd0, m_cnt});
    if (pend_m) chk("din", {32'd0, fifo_din}, {32'd0, exp_q[0].w});
    if (fifo_we) last_wr = fifo_din;
    @(posedge wr_clk);
    #1;
    if (c) begin
      model_reset();
    end else begin
      if (e_we) begin
        wd = exp_q.pop_front();
        m_cnt++;
        if (!in_burst) begin
          if (BURST > 1 && !wd.last) begin
            in_burst = 1'b1;
            bn       = 1;
          end
        end else begin
          bn++;
          if (bn == BURST || wd.last) in_burst = 1'b0;
        end
      end
      if (took) begin
        acc_q.push_back(d);
        if (acc_q.size() == NB || l) begin
          w = '0;
          foreach (acc_q[i]) w[8*i +: 8] = acc_q[i];
          wd.w    = w;
          wd.last = l;
          exp_q.push_back(wd);
          acc_q.delete();
        end
      end
    end
  endtask

  initial begin
    logic        tk;
    logic [7:0]  b;
    logic [31:0] din_hold;
    int          n;

    rst = 1'b0; clr = 1'b0; s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b0;
    fifo_full = 1'b0; fifo_full_n = 1'b0; last_wr = '0;
    model_reset();

    for (int i = 0; i < 3; i++) begin
      @(posedge wr_clk);
      #1;
      chk($sformatf("rst%0d_we", i), {63'd0, fifo_we}, 64'd0);
      chk($sformatf("rst%0d_ready", i), {63'd0, s_ready}, 64'd0);
      chk($sformatf("rst%0d_din", i), {32'd0, fifo_din}, 64'd0);
      chk($sformatf("rst%0d_cnt", i), {48'd0, wr_cnt}, 64'd0);
      chk($sformatf("rst%0d_busy", i), {63'd0, busy}, 64'd0);
    end
    rst = 1'b1; s_valid = 1'b0;
    #1;
    chk("rst_release_ready", {63'd0, s_ready}, 64'd1);
    @(posedge wr_clk);
    #1;

    // Streaming 0x01..0x08, then a 3-byte packet closing the burst, then a 1-byte packet
    tbl.push_back(mk(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 32'h0,        16'd0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 32'h0,        16'd0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 32'h0,        16'd0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 32'h0,        16'd0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 32'h04030201, 16'd0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 32'h04030201, 16'd1, 1'b1));
    tbl.push_back(mk(1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 32'h04030201, 16'd1, 1'b1));
    tbl.push_back(mk(1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 32'h04030201, 16'd1, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h08070605, 16'd1, 1'b1));
    tbl.push_back(mk(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 32'h08070605, 16'd2, 1'b1));
    tbl.push_back(mk(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 32'h08070605, 16'd2, 1'b1));
    tbl.push_back(mk(1'b1, 8'hCC, 1'b1, 1'b0, 1'b1, 32'h08070605, 16'd2, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h00CCBBAA, 16'd2, 1'b1));
    tbl.push_back(mk(1'b1, 8'hDD, 1'b1, 1'b0, 1'b1, 32'h00CCBBAA, 16'd3, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h000000DD, 16'd3, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h000000DD, 16'd4, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t t;
      t = tbl[i];
      s_valid = t.v; s_data = t.d; s_last = t.l; fifo_full = t.f; fifo_full_n = t.fn;
      #1;
      chk($sformatf("row%0d_we", i), {63'd0, fifo_we}, {63'd0, t.we});
      chk($sformatf("row%0d_ready", i), {63'd0, s_ready}, {63'd0, t.rdy});
      chk($sformatf("row%0d_din", i), {32'd0, fifo_din}, {32'd0, t.din});
      chk($sformatf("row%0d_cnt", i), {48'd0, wr_cnt}, {48'd0, t.cnt});
      chk($sformatf("row%0d_busy", i), {63'd0, busy}, {63'd0, t.busy});
      @(posedge wr_clk);
      #1;
    end

    s_valid = 1'b0; clr = 1'b1;
    @(posedge wr_clk);
    #1;
    clr = 1'b0;
    model_reset();
    chk("clr_resync_cnt", {48'd0, wr_cnt}, 64'd0);
    chk("clr_resync_busy", {63'd0, busy}, 64'd0);

    // Burst gate: nearly-full holds the first word until it drops for one cycle
    b = 8'h10;
    n = 0;
    while (exp_q.size() == 0 && n < 20) begin
      step(1'b1, b, 1'b0, 1'b0, 1'b1, 1'b0, tk);
      if (tk) b++;
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, b, 1'b0, 1'b0, 1'b1, 1'b0, tk);
      if (tk) b++;
    end
    chk("gate_hold_cnt", {48'd0, wr_cnt}, 64'd0);
    step(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0, tk);
    if (tk) b++;
    chk("gate_open_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 30; i++) begin
      step(1'b1, b, 1'b0, 1'b0, 1'b1, 1'b0, tk);
      if (tk) b++;
    end
    s_valid = 1'b1; fifo_full = 1'b0; fifo_full_n = 1'b1;
    #1;
    chk("gate_burst_cnt", {48'd0, wr_cnt}, 64'd4);
    chk("gate_after_busy", {63'd0, busy}, 64'd0);
    chk("gate_fifth_we", {63'd0, fifo_we}, 64'd0);

    // Full stall inside a burst
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, tk);
    n = 0;
    while (exp_q.size() == 0 && n < 8) begin
      step(1'b1, b, 1'b0, 1'b0, 1'b1, 1'b0, tk);
      if (tk) b++;
      n++;
    end
    din_hold = fifo_din;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, b, 1'b0, 1'b1, 1'b0, 1'b0, tk);
      if (tk) b++;
    end
    chk("stall_din", {32'd0, fifo_din}, {32'd0, din_hold});
    chk("stall_busy", {63'd0, busy}, 64'd1);
    chk("stall_cnt", {48'd0, wr_cnt}, 64'd5);
    step(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0, tk);
    chk("stall_resume_cnt", {48'd0, wr_cnt}, 64'd6);
    chk("stall_resume_busy", {63'd0, busy}, 64'd1);
    chk("stall_resume_word", {32'd0, last_wr}, {32'd0, din_hold});

    // clr in the middle of a word discards the partial bytes
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, tk);
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, tk);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, tk);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, tk);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h33 + i), 1'b0, 1'b0, 1'b0, 1'b0, tk);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, tk);
    chk("clr_word", {32'd0, last_wr}, 64'h36353433);
    chk("clr_cnt", {48'd0, wr_cnt}, 64'd1);

    for (int i = 0; i < 3000; i++) begin
      logic c, v;
      c = ($urandom_range(0, 199) == 0);
      v = c ? 1'b0 : ($urandom_range(0, 3) != 0);
      step(v, 8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0), c, tk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
